// File: rtl/muldiv_hilo_unit_if.sv
// rtl/muldiv_hilo_unit_if.sv - request and HI/LO result bundle for the multiply/divide unit
interface muldiv_hilo_unit_if #(
   parameter int WIDTH = 32
) ();
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, op, a, b, input busy, done, hi, lo);
   modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_hilo_unit.sv
// rtl/muldiv_hilo_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO
module muldiv_hilo_unit #(
   parameter int WIDTH = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   muldiv_hilo_unit_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   state_t             r_state;
   state_t             w_next;
   // Mult: {partial product, multiplier}. Div: {remainder, dividend/quotient}.
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_opd;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [CW-1:0]      r_cnt;
   logic               r_is_div;
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_dbz;
   logic               r_done;

   logic               w_idle;
   logic               w_start_arith;
   logic               w_start_mt;
   logic               w_neg_a;
   logic               w_neg_b;
   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [WIDTH:0]     w_mul_sum;
   logic [WIDTH:0]     w_div_shift;
   logic               w_div_ge;
   logic [WIDTH-1:0]   w_div_diff;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;

   assign w_idle        = (r_state == S_IDLE);
   // Requests are only honoured in IDLE, so a start during CALC/FIX is dropped.
   assign w_start_arith = w_idle && bus.start && (bus.op[2] == 1'b0);
   assign w_start_mt    = w_idle && bus.start && (bus.op[2:1] == 2'b10);
   // op[0] clear selects the signed variants (MULT, DIV).
   assign w_neg_a       = ~bus.op[0] && bus.a[WIDTH-1];
   assign w_neg_b       = ~bus.op[0] && bus.b[WIDTH-1];
   assign w_abs_a       = w_neg_a ? -bus.a : bus.a;
   assign w_abs_b       = w_neg_b ? -bus.b : bus.b;

   assign w_mul_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : '0);
   // Shifted partial remainder is below 2*divisor, so the difference always fits WIDTH bits.
   assign w_div_shift   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
   assign w_div_ge      = (w_div_shift >= {1'b0, r_opd});
   assign w_div_diff    = w_div_shift[WIDTH-1:0] - r_opd;
   assign w_quo         = r_acc[WIDTH-1:0];
   assign w_rem         = r_acc[2*WIDTH-1:WIDTH];

   assign bus.busy      = ~w_idle;
   assign bus.done      = r_done;
   assign bus.hi        = r_hi;
   assign bus.lo        = r_lo;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next state: IDLE -> CALC for WIDTH iterations -> FIX for one cycle -> IDLE.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_start_arith) w_next = S_CALC;
         S_CALC:  if (r_cnt == CW'(1)) w_next = S_FIX;
         S_FIX:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Scratch datapath: latch magnitudes and sign flags, then one shift-add or restoring step per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc    <= '0;
         r_opd    <= '0;
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_dbz    <= 1'b0;
      end else if (w_start_arith) begin
         r_is_div <= bus.op[1];
         r_dbz    <= bus.op[1] && (bus.b == '0);
         r_neg_q  <= w_neg_a ^ w_neg_b;
         r_neg_r  <= w_neg_a;
         r_opd    <= bus.op[1] ? w_abs_b : w_abs_a;
         r_acc    <= {{WIDTH{1'b0}}, (bus.op[1] ? w_abs_a : w_abs_b)};
         r_cnt    <= CW'(WIDTH);
      end else if (r_state == S_CALC) begin
         r_cnt <= r_cnt - CW'(1);
         if (r_is_div)
            r_acc <= w_div_ge ? {w_div_diff, r_acc[WIDTH-2:0], 1'b1}
                              : {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
         else
            r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
      end
   end

   // HI/LO and done: sign-corrected result in FIX, or a direct MTHI/MTLO write from IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hi   <= '0;
         r_lo   <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= (r_state == S_FIX) || w_start_mt;
         if (r_state == S_FIX) begin
            if (r_is_div) begin
               // Divide by zero leaves |a| as remainder; re-applying the dividend sign restores raw a.
               r_hi <= r_neg_r ? -w_rem : w_rem;
               r_lo <= r_dbz ? '1 : (r_neg_q ? -w_quo : w_quo);
            end else begin
               {r_hi, r_lo} <= r_neg_q ? -r_acc : r_acc;
            end
         end else if (w_start_mt) begin
            if (bus.op[0]) r_lo <= bus.a;
            else           r_hi <= bus.a;
         end
      end
   end
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// tb/tb_muldiv_hilo_unit.sv - scoreboard bench for the multiply/divide HI/LO unit
module tb_muldiv_hilo_unit;
   localparam int W = 32;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   exp_t        sbq[$];
   logic [31:0] m_hi;
   logic [31:0] m_lo;
   int          n_cmp = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   muldiv_hilo_unit_if #(.WIDTH(W)) bus ();
   muldiv_hilo_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   function automatic bit model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
      longint      sa, sbv, q, r;
      logic [63:0] p, t;
      hi = m_hi; lo = m_lo; model = 1'b1;
      sa = longint'($signed(a)); sbv = longint'($signed(b));
      case (op)
         3'd0: begin p = sa * sbv; {hi, lo} = p; end
         3'd1: begin p = {32'b0, a} * {32'b0, b}; {hi, lo} = p; end
         3'd2: if (b == 0) begin hi = a; lo = '1; end
               else begin
                  q = sa / sbv; r = sa % sbv;
                  t = q; lo = t[31:0];
                  t = r; hi = t[31:0];
               end
         3'd3: if (b == 0) begin hi = a; lo = '1; end
               else begin lo = a / b; hi = a % b; end
         3'd4: hi = a;
         3'd5: lo = a;
         default: model = 1'b0;
      endcase
   endfunction

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [31:0] h, l;
      if (model(op, a, b, h, l)) begin
         e.hi = h; e.lo = l; e.lat = op[2] ? 0 : W + 1;
         sbq.push_back(e);
         m_hi = h; m_lo = l;
      end
      @(negedge clk);
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_result(input string name, input int skip);
      int   k, nb;
      exp_t e;
      k = skip; nb = 0;
      while (bus.done !== 1'b1 && k < 80) begin
         if (bus.busy === 1'b1) nb++;
         @(negedge clk);
         k++;
      end
      if (sbq.size() == 0) begin
         n_cmp++; n_fail++;
         $display("FAIL %s scoreboard: got a result with nothing expected", name);
         return;
      end
      e = sbq.pop_front();
      n_cmp++;
      if (bus.done !== 1'b1) begin
         n_fail++;
         $display("FAIL %s done: got no pulse within %0d cycles, want one", name, k);
         return;
      end
      n_cmp++;
      if (bus.hi !== e.hi) begin n_fail++; $display("FAIL %s hi: got %h want %h", name, bus.hi, e.hi); end
      n_cmp++;
      if (bus.lo !== e.lo) begin n_fail++; $display("FAIL %s lo: got %h want %h", name, bus.lo, e.lo); end
      n_cmp++;
      if (k !== e.lat) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", name, k, e.lat); end
      n_cmp++;
      if (nb !== e.lat - skip) begin n_fail++; $display("FAIL %s busy_cycles: got %0d want %0d", name, nb, e.lat - skip); end
      n_cmp++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_at_done: got %b want 0", name, bus.busy); end
      @(negedge clk);
      n_cmp++;
      if (bus.done !== 1'b0) begin n_fail++; $display("FAIL %s done_width: got %b want 0", name, bus.done); end
   endtask

   task automatic check_quiet(input string name, input int n);
      int nd, nbz;
      nd = 0; nbz = 0;
      repeat (n) begin
         @(negedge clk);
         if (bus.done === 1'b1) nd++;
         if (bus.busy === 1'b1) nbz++;
      end
      n_cmp++;
      if (nd !== 0) begin n_fail++; $display("FAIL %s stray_done: got %0d pulses want 0", name, nd); end
      n_cmp++;
      if (nbz !== 0) begin n_fail++; $display("FAIL %s stray_busy: got %0d cycles want 0", name, nbz); end
      n_cmp++;
      if (bus.hi !== m_hi) begin n_fail++; $display("FAIL %s hold_hi: got %h want %h", name, bus.hi, m_hi); end
      n_cmp++;
      if (bus.lo !== m_lo) begin n_fail++; $display("FAIL %s hold_lo: got %h want %h", name, bus.lo, m_lo); end
   endtask

   task automatic check_zero(input string name);
      n_cmp++;
      if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL %s hi: got %h want 0", name, bus.hi); end
      n_cmp++;
      if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL %s lo: got %h want 0", name, bus.lo); end
      n_cmp++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL %s busy: got %b want 0", name, bus.busy); end
      n_cmp++;
      if (bus.done !== 1'b0) begin n_fail++; $display("FAIL %s done: got %b want 0", name, bus.done); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      m_hi = '0; m_lo = '0;
   endtask

   task automatic test_arith();
      issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF); wait_result("multu_max", 0);
      issue(3'd0, 32'hFFFFFFFD, 32'd7);        wait_result("mult_neg", 0);
      issue(3'd2, 32'hFFFFFFF9, 32'd2);        wait_result("div_neg", 0);
      issue(3'd3, 32'd100, 32'd0);             wait_result("divu_zero", 0);
      issue(3'd2, 32'h80000000, 32'hFFFFFFFF); wait_result("div_ovf", 0);
      issue(3'd2, 32'hFFFFFFFB, 32'd0);        wait_result("div_zero_neg", 0);
      issue(3'd0, 32'h80000000, 32'h80000000); wait_result("mult_minmin", 0);
   endtask

   task automatic test_mt();
      issue(3'd4, 32'h00001234, 32'h0); wait_result("mthi", 0);
      issue(3'd5, 32'hCAFEF00D, 32'h0); wait_result("mtlo", 0);
   endtask

   task automatic test_noop();
      issue(3'd6, 32'h11111111, 32'h2); check_quiet("noop_110", 5);
      issue(3'd7, 32'h22222222, 32'h3); check_quiet("noop_111", 5);
   endtask

   task automatic test_busy_ignore();
      logic [31:0] ph, pl;
      ph = m_hi; pl = m_lo;
      issue(3'd1, 32'd3, 32'd5);
      repeat (8) @(negedge clk);
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'd9; bus.b = 32'd3;
      n_cmp++;
      if (bus.hi !== ph || bus.lo !== pl) begin
         n_fail++; $display("FAIL busy_hold: got %h_%h want %h_%h", bus.hi, bus.lo, ph, pl);
      end
      @(negedge clk);
      bus.start = 1'b0;
      wait_result("busy_ignore", 10);
      check_quiet("busy_ignore_after", 40);
   endtask

   task automatic test_fix_start();
      exp_t e;
      issue(3'd1, 32'h12345678, 32'h9ABCDEF0);
      repeat (32) @(negedge clk);
      n_cmp++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
         n_fail++; $display("FAIL fix_state: got busy=%b done=%b want busy=1 done=0", bus.busy, bus.done);
      end
      bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'hDEADBEEF; bus.b = 32'h0;
      @(negedge clk);
      bus.start = 1'b0;
      e = sbq.pop_front();
      n_cmp++;
      if (bus.done !== 1'b1) begin n_fail++; $display("FAIL fix_done: got %b want 1", bus.done); end
      n_cmp++;
      if (bus.hi !== e.hi || bus.lo !== e.lo) begin
         n_fail++; $display("FAIL fix_result: got %h_%h want %h_%h", bus.hi, bus.lo, e.hi, e.lo);
      end
      check_quiet("fix_start_after", 4);
   endtask

   task automatic test_back_to_back();
      logic [2:0]  op;
      logic [31:0] a, b;
      for (int i = 0; i < 8; i++) begin
         op = 3'($urandom_range(0, 3));
         a  = $urandom;
         b  = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
         if (i == 5) a = 32'($urandom_range(0, 50));
         issue(op, a, b);
         wait_result($sformatf("b2b_%0d_op%0d", i, op), 0);
      end
   endtask

   task automatic test_reset_mid();
      issue(3'd4, 32'hA5A5A5A5, 32'h0); wait_result("pre_reset_mthi", 0);
      issue(3'd1, 32'h0000FFFF, 32'h00010001);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_zero("reset_mid");
      void'(sbq.pop_back());
      m_hi = '0; m_lo = '0;
      @(negedge clk);
      rst_n = 1'b1;
      check_quiet("reset_mid_after", 40);
      issue(3'd0, 32'd6, 32'hFFFFFFF9); wait_result("post_reset_mult", 0);
   endtask

   initial begin
      test_reset();
      test_arith();
      test_mt();
      test_noop();
      test_busy_ignore();
      test_fix_start();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
